// File: rtl/cpu_move_picker.sv
// Computer-move picker: spins an upstream LFSR, samples it and probes the captured board for a free cell.
// Optional build macro PICKER_CENTER_FIRST_EN: take the centre cell immediately whenever it is free.
module cpu_move_picker #(
  parameter int SPIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [8:0] occupied,
  input  logic [3:0] rnd,
  output logic       lfsr_en,
  output logic       busy,
  output logic       move_valid,
  output logic [3:0] move_idx,
  output logic       no_move,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SPIN   = 3'd1,
    SAMPLE = 3'd2,
    PROBE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SPIN_LOAD = 4'(SPIN_CYCLES);

  state_t     state, state_next;
  logic [3:0] spin_cnt;
  logic [3:0] candidate;
  logic [8:0] board;
  logic       board_full;
  logic       center_take;
  logic       cand_free;

  assign board_full = (occupied == 9'h1FF);
`ifdef PICKER_CENTER_FIRST_EN
  assign center_take = ~occupied[4];
`else
  assign center_take = 1'b0;
`endif
  assign cand_free = ~board[candidate];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        // Full-board check wins over the centre shortcut.
        if (req) begin
          if (board_full || center_take) state_next = DONE;
          else                           state_next = SPIN;
        end
      end
      SPIN:    if (spin_cnt <= 4'd1) state_next = SAMPLE;
      SAMPLE:  state_next = PROBE;
      PROBE:   if (cand_free) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    lfsr_en    = (state == SPIN);
    busy       = (state != IDLE);
    move_valid = (state == DONE);
    state_dbg  = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spin_cnt  <= 4'd0;
      candidate <= 4'd0;
      board     <= 9'd0;
      move_idx  <= 4'd0;
      no_move   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            board <= occupied;
            if (board_full) begin
              no_move <= 1'b1;
            end else begin
              no_move  <= 1'b0;
              spin_cnt <= SPIN_LOAD;
              if (center_take) move_idx <= 4'd4;
            end
          end
        end
        SPIN:   spin_cnt <= spin_cnt - 4'd1;
        // Fold the 4-bit LFSR value onto cells 0..8.
        SAMPLE: candidate <= (rnd <= 4'd8) ? rnd : rnd - 4'd9;
        PROBE: begin
          if (cand_free) move_idx  <= candidate;
          else           candidate <= (candidate == 4'd8) ? 4'd0 : candidate + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cpu_move_picker.md
CPU_MOVE_PICKER -- requirements
Module: cpu_move_picker

Interface
REQ-001 SHALL have parameter SPIN_CYCLES, default 3, number of cycles the LFSR is advanced before sampling (legal 1..15).
REQ-002 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  1  request for a computer move; sampled only in IDLE.
REQ-005 SHALL have port occupied  input  9  board occupancy, bit i = cell i taken.
REQ-006 SHALL have port rnd  input  4  current value of the upstream LFSR.
REQ-007 SHALL have port lfsr_en  output  1  advance enable to the upstream LFSR.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port move_valid  output  1  one-cycle pulse, move result available.
REQ-010 SHALL have port move_idx  output  4  chosen cell 0..8.
REQ-011 SHALL have port no_move  output  1  qualifies move_valid: board was full.

Function
REQ-012 SHALL implement FSM states IDLE, SPIN, SAMPLE, PROBE, DONE.
REQ-013 SHALL, in IDLE with req=1, capture occupied into an internal board register; only the captured copy is used until return to IDLE.
REQ-014 SHALL, on req in IDLE with occupied=9'h1FF, go to DONE with no_move=1 and move_idx unchanged.
REQ-015 SHALL, on req in IDLE otherwise, go to SPIN and load a spin counter with SPIN_CYCLES.
REQ-016 SHALL drive lfsr_en=1 in SPIN only, for exactly SPIN_CYCLES consecutive cycles, then go to SAMPLE.
REQ-017 SHALL, in SAMPLE, load candidate = rnd if rnd<=8, else rnd-9; then go to PROBE.
REQ-018 SHALL, in PROBE, test one cell per cycle: if candidate is free, load move_idx=candidate and go to DONE; else candidate = (candidate==8) ? 0 : candidate+1.
REQ-019 SHALL spend 1..9 cycles in PROBE; termination guaranteed because the board is not full.
REQ-020 SHALL assert move_valid for exactly the one DONE cycle, then return to IDLE.
REQ-021 SHALL hold move_idx and no_move stable from DONE until the next DONE.
REQ-022 SHALL clear no_move when a non-full request is accepted.
REQ-023 SHALL ignore req while busy=1; no queuing.
REQ-024 SHALL give move_valid exactly SPIN_CYCLES+2+P cycles after the req cycle, where P = probe cycles; 1 cycle for the full-board case.

Reset
REQ-025 SHALL, on reset, force state IDLE, lfsr_en=0, busy=0, move_valid=0, no_move=0, move_idx=0, and clear the counter, candidate and board registers.
REQ-026 SHALL, on reset in any state, including mid-SPIN or mid-PROBE, abandon the operation with no move_valid pulse.
REQ-027 SHALL give reset priority over req in the same cycle.

Configuration
REQ-028 SHALL, with macro PICKER_CENTER_FIRST_EN defined and req in IDLE with occupied[4]=0, go directly to DONE with move_idx=4: move_valid the cycle after req, lfsr_en never asserted.
REQ-029 SHALL, without PICKER_CENTER_FIRST_EN, treat cell 4 like any other cell.
REQ-030 SHALL give the full-board check (REQ-014) priority over center-first.

Verification
REQ-031 SHALL cover: SPIN_CYCLES=3, occupied=0, rnd=5 held -> lfsr_en high 3 cycles, move_valid 6 cycles after req, move_idx=5, no_move=0.
REQ-032 SHALL cover: occupied=9'h1FE, rnd=3 -> probe 3..8 occupied, wrap to 0, move_idx=0, P=7.
REQ-033 SHALL cover: occupied=9'h1FF -> move_valid next cycle, no_move=1, lfsr_en never high.
REQ-034 SHALL cover: rnd=4'hC, occupied=0 -> candidate 3, move_idx=3.
REQ-035 SHALL cover: reset asserted in the second SPIN cycle -> all outputs 0, no move_valid; a new req afterwards completes normally.
REQ-036 SHALL cover: PICKER_CENTER_FIRST_EN defined, occupied=0 -> move_idx=4 one cycle after req; req held through busy yields one result per accepted request.
